// File: rtl/lab1_led_pulse_pkg.sv
// Shared constants for the LED output PIO: register map, STATUS bit layout
// and pulse-engine state encoding.
package lab1_led_pulse_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_PULSE     = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK  = 3'd6;

    localparam int unsigned BUSY_BIT = 0;
    localparam int unsigned DONE_BIT = 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/lab1_led_pulse_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
interface lab1_led_pulse_if;
    import lab1_led_pulse_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/lab1_led_pulse_timer.sv
// One-shot pulse engine: holds a mask high for len cycles, retriggerable,
// and strobes expire when the pulse ends (or a zero-length start is seen).
module lab1_led_pulse_timer
    import lab1_led_pulse_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [WIDTH-1:0] start_mask,
    output logic [WIDTH-1:0] pulse_mask,
    output logic             busy,
    output logic             expire
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             len_zero;

    assign len_zero = (len == '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mask_d  = mask_q;
        expire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_zero) begin
                        expire = 1'b1;
                    end else begin
                        mask_d  = start_mask;
                        count_d = len;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // A retrigger wins over expiry landing in the same cycle.
                if (start) begin
                    if (len_zero) begin
                        mask_d  = '0;
                        count_d = '0;
                        expire  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        mask_d  = mask_q | start_mask;
                        count_d = len;
                    end
                end else if (count_q == CNT_W'(1)) begin
                    mask_d  = '0;
                    count_d = '0;
                    expire  = 1'b1;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mask_q  <= mask_d;
        end
    end

    assign pulse_mask = mask_q;
    assign busy       = (state_q == BUSY);

endmodule

// File: rtl/lab1_led_pulse.sv
// LED output PIO: data register with set/clear aliases, one-shot pulse
// engine and a maskable pulse-done interrupt; 1-cycle registered reads.
module lab1_led_pulse
    import lab1_led_pulse_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    lab1_led_pulse_if.slave  bus,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic              wr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic              done_q, done_d, done_clr;
    logic              irq_mask_q, irq_mask_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              pulse_start;
    logic [WIDTH-1:0]  pulse_mask;
    logic              busy;
    logic              expire;

    assign wr          = bus.chipselect & ~bus.write_n;
    assign wdata       = bus.writedata[WIDTH-1:0];
    assign pulse_start = wr & (bus.address == ADDR_PULSE);

    lab1_led_pulse_timer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (pulse_start),
        .len        (len_q),
        .start_mask (wdata),
        .pulse_mask (pulse_mask),
        .busy       (busy),
        .expire     (expire)
    );

    always_comb begin
        data_d     = data_q;
        len_d      = len_q;
        irq_mask_d = irq_mask_q;
        done_clr   = 1'b0;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:      data_d     = wdata;
                ADDR_OUTSET:    data_d     = data_q | wdata;
                ADDR_OUTCLEAR:  data_d     = data_q & ~wdata;
                ADDR_PULSE_LEN: len_d      = bus.writedata[CNT_W-1:0];
                ADDR_STATUS:    done_clr   = bus.writedata[DONE_BIT];
                ADDR_IRQ_MASK:  irq_mask_d = bus.writedata[0];
                default:        ;
            endcase
        end
        // A completing pulse outranks a simultaneous W1C.
        done_d = expire | (done_q & ~done_clr);
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:      readdata_d[WIDTH-1:0] = data_q;
            ADDR_PULSE_LEN: readdata_d[CNT_W-1:0] = len_q;
            ADDR_PULSE:     readdata_d[WIDTH-1:0] = pulse_mask;
            ADDR_STATUS: begin
                readdata_d[BUSY_BIT] = busy;
                readdata_d[DONE_BIT] = done_q;
            end
            ADDR_IRQ_MASK:  readdata_d[0] = irq_mask_q;
            default:        ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            len_q      <= '0;
            done_q     <= 1'b0;
            irq_mask_q <= 1'b0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            len_q      <= len_d;
            done_q     <= done_d;
            irq_mask_q <= irq_mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign out_port     = data_q | pulse_mask;
    assign irq          = done_q & irq_mask_q;

endmodule

// File: tb/tb_lab1_led_pulse.sv
// Directed bench for lab1_led_pulse: register map, pulse timing, retrigger,
// irq masking, zero-length pulses, done set/clear collision and async reset.
module tb_lab1_led_pulse;
    import lab1_led_pulse_pkg::*;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned CNT_W = 32;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] out_port;
    logic             irq;
    int               checks = 0;
    int               errors = 0;

    lab1_led_pulse_if bus ();

    lab1_led_pulse #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capturing posedge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] rd);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(negedge clk);
        rd             = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          n;

        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_out_port", 32'(out_port), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("reset_read_addr%0d", a), rd, 32'h0);
        end

        // Data register and set/clear aliases; upper writedata bits ignored.
        bus_write(ADDR_DATA, 32'hABCD_E005);
        bus_write(ADDR_OUTSET, 32'h0000_0300);
        bus_write(ADDR_OUTCLEAR, 32'h0000_0001);
        check("setclr_out_port", 32'(out_port), 32'h304);
        bus_read(ADDR_DATA, rd);
        check("setclr_read_data", rd, 32'h304);
        bus_read(ADDR_OUTSET, rd);
        check("outset_reads_zero", rd, 32'h0);

        // 5-cycle pulse.
        bus_write(ADDR_DATA, 32'h0);
        bus_write(ADDR_PULSE_LEN, 32'd5);
        bus_read(ADDR_PULSE_LEN, rd);
        check("pulse_len_read", rd, 32'd5);
        bus_write(ADDR_PULSE, 32'h0F0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("pulse5_on_cycle%0d", i + 1), 32'(out_port), 32'h0F0);
            if (i == 0) begin
                bus_read(ADDR_STATUS, rd);
                check("pulse5_status_busy", rd, 32'h1);
            end else begin
                @(negedge clk);
            end
        end
        check("pulse5_off", 32'(out_port), 32'h0);
        bus_read(ADDR_STATUS, rd);
        check("pulse5_status_done", rd, 32'h2);
        check("pulse5_irq_masked", 32'(irq), 32'h0);
        bus_write(ADDR_STATUS, 32'h2);

        // IRQ enabled.
        bus_write(ADDR_IRQ_MASK, 32'h1);
        bus_write(ADDR_PULSE_LEN, 32'd3);
        bus_write(ADDR_PULSE, 32'h001);
        check("irq_pulse_on", 32'(out_port), 32'h001);
        @(negedge clk);
        @(negedge clk);
        check("irq_low_last_cycle", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_rises_at_end", 32'(irq), 32'h1);
        check("irq_pulse_off", 32'(out_port), 32'h0);
        bus_write(ADDR_STATUS, 32'h2);
        check("irq_cleared_w1c", 32'(irq), 32'h0);
        bus_read(ADDR_IRQ_MASK, rd);
        check("irq_mask_read", rd, 32'h1);

        // IRQ masked: done still latches.
        bus_write(ADDR_IRQ_MASK, 32'h0);
        bus_write(ADDR_PULSE, 32'h001);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("irq_masked_stays_low", 32'(irq), 32'h0);
        bus_read(ADDR_STATUS, rd);
        check("irq_masked_status_done", rd, 32'h2);
        bus_write(ADDR_STATUS, 32'h2);

        // Retrigger after 4 cycles of a 10-cycle pulse.
        bus_write(ADDR_PULSE_LEN, 32'd10);
        bus_write(ADDR_PULSE, 32'h001);
        check("retrig_first_on", 32'(out_port), 32'h001);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("retrig_cycle4", 32'(out_port), 32'h001);
        bus_write(ADDR_PULSE, 32'h002);
        n = 0;
        while (out_port == 10'h003 && n < 30) begin
            n++;
            @(negedge clk);
        end
        check("retrig_combined_cycles", 32'(n), 32'd10);
        check("retrig_off", 32'(out_port), 32'h0);
        bus_read(ADDR_STATUS, rd);
        check("retrig_status_done", rd, 32'h2);
        bus_write(ADDR_STATUS, 32'h2);

        // Zero-length pulse.
        bus_write(ADDR_PULSE_LEN, 32'd0);
        bus_write(ADDR_PULSE, 32'h3FF);
        check("len0_no_pulse", 32'(out_port), 32'h0);
        bus_read(ADDR_STATUS, rd);
        check("len0_status", rd, 32'h2);
        bus_read(ADDR_PULSE, rd);
        check("len0_pulse_mask", rd, 32'h0);
        bus_write(ADDR_STATUS, 32'h2);

        // Done W1C collides with expiry of a 1-cycle pulse; data bit survives.
        bus_write(ADDR_DATA, 32'h001);
        bus_write(ADDR_PULSE_LEN, 32'd1);
        bus_write(ADDR_PULSE, 32'h003);
        check("len1_on", 32'(out_port), 32'h003);
        bus_write(ADDR_STATUS, 32'h2);
        check("len1_data_survives", 32'(out_port), 32'h001);
        bus_read(ADDR_STATUS, rd);
        check("done_set_wins", rd, 32'h2);

        // Async reset mid-pulse.
        bus_write(ADDR_DATA, 32'h0);
        bus_write(ADDR_IRQ_MASK, 32'h1);
        check("pre_reset_irq", 32'(irq), 32'h1);
        bus_write(ADDR_PULSE_LEN, 32'd5);
        bus_write(ADDR_PULSE, 32'h0F0);
        check("pre_reset_pulse", 32'(out_port), 32'h0F0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_out_port", 32'(out_port), 32'h0);
        check("async_reset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(ADDR_PULSE_LEN, rd);
        check("post_reset_len", rd, 32'h0);
        bus_read(ADDR_IRQ_MASK, rd);
        check("post_reset_irq_mask", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab1_led_pulse.md
Name: lab1_led_pulse

Overview:
- Avalon-MM slave output PIO. It is the write-side counterpart of the button input PIO and drives the board LEDs from the Nios II core.
- Provides a data register with atomic set/clear aliases, plus a hardware one-shot pulse engine. The engine holds selected bits high for a programmed number of clk cycles.
- Raises a maskable IRQ when a pulse completes.
- Sits on the system interconnect beside the button PIO, with a 1-cycle read latency.

Parameters:
- WIDTH, 10, number of output bits (LEDs).
- CNT_W, 32, width of the pulse length counter; must be 32 or less.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  3  word register index
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_port  out  WIDTH  LED drive
- irq  out  1  interrupt request, level

Behaviour:
- Write strobe wr = chipselect & ~write_n. Reads have no side effects.
- readdata is registered every clk and returns the mux of `address`, zero-extended. Data appears 1 cycle after address. Unmapped addresses read 0. Reset value is 0.
- Register map:
  - 0 DATA: RW, data_reg[WIDTH-1:0].
  - 1 OUTSET: W, data_reg |= writedata. Reads 0.
  - 2 OUTCLEAR: W, data_reg &= ~writedata. Reads 0.
  - 3 PULSE_LEN: RW, len_reg[CNT_W-1:0].
  - 4 PULSE: W, start or retrigger a pulse with mask writedata[WIDTH-1:0]. Reads the current pulse_mask.
  - 5 STATUS: bit0 busy (RO); bit1 done (write 1 to clear).
  - 6 IRQ_MASK: RW, bit0.
- out_port = data_reg | pulse_mask. This is a combinational OR of flops with no added latency.
- irq = done & irq_mask.
- Reset values: data_reg, len_reg, pulse_mask, count, done and irq_mask are all 0. State is IDLE, so out_port = 0 and irq = 0.
- FSM IDLE:
  - A PULSE write with len_reg != 0 loads pulse_mask <= writedata[WIDTH-1:0] and count <= len_reg, then goes to BUSY.
  - A PULSE write with len_reg == 0 sets done, leaves pulse_mask at 0 and stays in IDLE.
- FSM BUSY:
  - count decrements each cycle.
  - When count == 1 and no PULSE write occurs that cycle: pulse_mask <= 0, done <= 1, next state IDLE.
  - The masked bits are therefore high for exactly len_reg cycles, starting the cycle after the write.
- Retrigger: a PULSE write in BUSY sets pulse_mask <= pulse_mask | new mask and count <= len_reg (current value).
  - Retrigger takes precedence over expiry in the same cycle.
  - A retrigger write while len_reg == 0 ends the pulse immediately: mask cleared, done set, go to IDLE.
- busy = (state == BUSY).
- Writing PULSE_LEN during BUSY does not affect the running count. It applies only at the next start or retrigger.
- Done set and W1C clear in the same cycle: set wins, done = 1.
- DATA, OUTSET and OUTCLEAR are never affected by the pulse engine. A bit set in both data_reg and pulse_mask stays high after the pulse ends.
- Only writedata bits [WIDTH-1:0] are used for DATA, OUTSET, OUTCLEAR and PULSE. Upper bits are ignored.
- Async reset mid-pulse: everything returns to reset values immediately, out_port drops to 0 and irq deasserts.

Decomposition:
- Package lab1_led_pulse_pkg:
  - register address localparams ADDR_DATA=0 … ADDR_IRQ_MASK=6;
  - STATUS bit indices BUSY_BIT=0, DONE_BIT=1;
  - state encoding IDLE=1'b0, BUSY=1'b1.
- One sub-module, lab1_led_pulse_timer: holds the FSM and down-counter.
  - Inputs: start, len, start_mask.
  - Outputs: pulse_mask, busy, expire strobe.
- The top level holds the register file, the read mux, and done/irq.

Test Plan:
- Reset then read all addresses → all 0, out_port = 0, irq = 0. Assert reset_n low mid-pulse → out_port goes to 0 asynchronously.
- Write DATA=0x005, OUTSET=0x300, OUTCLEAR=0x001 → out_port = 0x304; DATA reads 0x304 one cycle after address.
- Write PULSE_LEN=5, PULSE=0x0F0, DATA=0 → out_port = 0x0F0 for exactly 5 cycles starting the cycle after the write, then 0x000. STATUS reads 0x1 while busy and 0x2 after expiry.
- Write IRQ_MASK=1, then PULSE_LEN=3, PULSE=0x001 → irq rises the cycle the pulse ends. Write STATUS=0x2 → irq falls. Repeat with IRQ_MASK=0 → irq stays 0 while STATUS bit1 = 1.
- Write PULSE_LEN=10, PULSE=0x001; on cycle 4 write PULSE=0x002 → out_port = 0x003 for 10 more cycles (total 14 high for bit0), then 0. Done is set once.
- Write PULSE_LEN=0, PULSE=0x3FF → out_port is never pulsed and STATUS=0x2. Also clear done in the same cycle as an expiry with len=1 → done reads 1.
